// File: rtl/hi_low_guesser_if.sv
// Hi-Low guesser bus: game control and hint inputs, guess and status outputs.
// The master side is the judge (or bench); the slave side is the guesser.
interface hi_low_guesser_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             hint_valid;
  logic [1:0]       hint;
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic [2:0]       guesses_left;
  logic             won;
  logic             lost;
  logic             error;

  modport master (
    output start, hint_valid, hint,
    input  guess, guess_valid, guesses_left, won, lost, error
  );

  modport slave (
    input  start, hint_valid, hint,
    output guess, guess_valid, guesses_left, won, lost, error
  );
endinterface

// File: rtl/hi_low_guesser.sv
// Automatic Hi-Low player: binary search over [lo, hi] driven by the judge's
// hints. Stops on a win, on running out of guesses, or on contradictory hints.
module hi_low_guesser #(
  parameter int WIDTH       = 4,
  parameter int MAX_GUESSES = 4
) (
  input  logic             clk,
  input  logic             reset,
  hi_low_guesser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WON   = 3'd3,
    S_LOST  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [2:0]       MAX_CNT = 3'(MAX_GUESSES);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_lo, w_lo_next;
  logic [WIDTH-1:0] r_hi, w_hi_next;
  logic [WIDTH-1:0] r_guess, w_guess_next;
  logic [2:0]       r_count, w_count_next;
  logic             r_error, w_error_next;

  // Interval candidate after a too-low / too-high hint
  logic             w_adj;
  logic [WIDTH-1:0] w_adj_lo, w_adj_hi;
  logic [2:0]       w_cnt_dec;

  // Sum carried in WIDTH+1 bits so lo = hi = max cannot wrap
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= MAX_VAL;
      r_guess <= '0;
      r_count <= MAX_CNT;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lo    <= w_lo_next;
      r_hi    <= w_hi_next;
      r_guess <= w_guess_next;
      r_count <= w_count_next;
      r_error <= w_error_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_next = r_state;
    w_lo_next    = r_lo;
    w_hi_next    = r_hi;
    w_guess_next = r_guess;
    w_count_next = r_count;
    w_error_next = r_error;
    w_adj        = 1'b0;
    w_adj_lo     = r_lo;
    w_adj_hi     = r_hi;
    // Saturating decrement: count never wraps below zero
    w_cnt_dec    = (r_count != 3'd0) ? (r_count - 3'd1) : 3'd0;

    case (r_state)
      S_IDLE, S_WON, S_LOST: begin
        if (bus.start) begin
          w_lo_next    = '0;
          w_hi_next    = MAX_VAL;
          w_count_next = MAX_CNT;
          w_error_next = 1'b0;
          w_guess_next = midpoint('0, MAX_VAL);
          w_state_next = S_ISSUE;
        end
      end

      S_ISSUE: w_state_next = S_WAIT;

      S_WAIT: begin
        if (bus.hint_valid) begin
          case (bus.hint)
            2'b11: begin
              w_count_next = w_cnt_dec;
              w_state_next = S_WON;
            end
            2'b01: begin
              if (r_guess == MAX_VAL) begin
                // "too low" for the largest value is impossible
                w_error_next = 1'b1;
                w_state_next = S_LOST;
              end else begin
                w_adj    = 1'b1;
                w_adj_lo = r_guess + WIDTH'(1);
              end
            end
            2'b10: begin
              if (r_guess == '0) begin
                // "too high" for zero is impossible
                w_error_next = 1'b1;
                w_state_next = S_LOST;
              end else begin
                w_adj    = 1'b1;
                w_adj_hi = r_guess - WIDTH'(1);
              end
            end
            default: ;
          endcase

          if (w_adj) begin
            w_lo_next    = w_adj_lo;
            w_hi_next    = w_adj_hi;
            w_count_next = w_cnt_dec;
            if (w_adj_lo > w_adj_hi) begin
              // Empty interval: earlier hints contradicted each other
              w_error_next = 1'b1;
              w_state_next = S_LOST;
            end else if (w_cnt_dec == 3'd0) begin
              w_state_next = S_LOST;
            end else begin
              w_guess_next = midpoint(w_adj_lo, w_adj_hi);
              w_state_next = S_ISSUE;
            end
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore-decoded outputs
  assign bus.guess        = r_guess;
  assign bus.guess_valid  = (r_state == S_ISSUE);
  assign bus.guesses_left = r_count;
  assign bus.won          = (r_state == S_WON);
  assign bus.lost         = (r_state == S_LOST);
  assign bus.error        = r_error;

endmodule

// File: tb/tb_hi_low_guesser.sv
// Bench for hi_low_guesser: directed games from the play rules plus random
// games (honest and lying judges) checked against an interval-arithmetic model.
module tb_hi_low_guesser;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hi_low_guesser_if #(.WIDTH(W)) bus_a ();
  hi_low_guesser_if #(.WIDTH(W)) bus_b ();

  // Instance A: MAX_GUESSES = 4. Instance B: MAX_GUESSES = 5, reaches the edges.
  hi_low_guesser #(.WIDTH(W), .MAX_GUESSES(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  hi_low_guesser #(.WIDTH(W), .MAX_GUESSES(5)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  logic       sel;
  logic       start, hv;
  logic [1:0] hint;

  assign bus_a.start      = start & ~sel;
  assign bus_a.hint_valid = hv & ~sel;
  assign bus_a.hint       = hint;
  assign bus_b.start      = start & sel;
  assign bus_b.hint_valid = hv & sel;
  assign bus_b.hint       = hint;

  logic [W-1:0] ob_guess;
  logic         ob_gv, ob_won, ob_lost, ob_err;
  logic [2:0]   ob_gl;
  assign ob_guess = sel ? bus_b.guess        : bus_a.guess;
  assign ob_gv    = sel ? bus_b.guess_valid  : bus_a.guess_valid;
  assign ob_won   = sel ? bus_b.won          : bus_a.won;
  assign ob_lost  = sel ? bus_b.lost         : bus_a.lost;
  assign ob_err   = sel ? bus_b.error        : bus_a.error;
  assign ob_gl    = sel ? bus_b.guesses_left : bus_a.guesses_left;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Plays one game. Hints come from hq first, then from a lying or honest judge.
  // dly < 0 means a random 0..3 cycle reply delay. Guesses are packed as nibbles.
  task automatic play(input bit s, input int secret, input bit liar, input int dly,
                      input int hq[$], output int seq, output int rwon,
                      output int rlost, output int rerr, output int rgl);
    int mx, lo, hi, cnt, g, h, d, iter;
    bit done, w, err;
    sel = s; mx = (1 << W) - 1; lo = 0; hi = mx; cnt = s ? 5 : 4;
    done = 0; w = 0; err = 0; seq = 0; iter = 0; g = 0;
    // start together with a hint: start must win
    @(negedge clk); start = 1'b1; hv = 1'($urandom_range(0, 1)); hint = 2'b11;
    @(negedge clk); start = 1'b0; hv = 1'b0; hint = 2'b00;
    while (!done && iter < 10) begin
      iter++;
      g = (lo + hi) / 2;
      seq = (seq << 4) | g;
      check("guess_valid", int'(ob_gv), 1);
      check("guess", int'(ob_guess), g);
      d = (dly >= 0) ? dly : int'($urandom_range(0, 3));
      // a hint during ISSUE must be ignored, not queued
      if (d > 0) begin hv = 1'b1; hint = 2'($urandom_range(1, 3)); end
      @(negedge clk); hv = 1'b0; hint = 2'b00;
      check("wait_entry", int'({ob_gv, ob_won, ob_lost}), 0);
      for (int i = 0; i < d; i++) begin
        case ($urandom_range(0, 2))
          0:       start = 1'b1;
          1:       begin hv = 1'b1; hint = 2'b00; end
          default: ;
        endcase
        @(negedge clk); start = 1'b0; hv = 1'b0;
        check("wait_hold", int'({ob_gv, ob_won, ob_lost}), 0);
        check("wait_guess", int'(ob_guess), g);
      end
      if (hq.size() > 0)  h = hq.pop_front();
      else if (liar)      h = int'($urandom_range(1, 3));
      else                h = (g < secret) ? 1 : (g > secret) ? 2 : 3;
      hv = 1'b1; hint = 2'(h);
      @(negedge clk); hv = 1'b0; hint = 2'b00;
      if (h == 3) begin
        cnt--; w = 1; done = 1;
      end else if ((h == 1 && g == mx) || (h == 2 && g == 0)) begin
        err = 1; done = 1;
      end else begin
        if (h == 1) lo = g + 1; else hi = g - 1;
        cnt--;
        if (lo > hi) begin err = 1; done = 1; end
        else if (cnt == 0) done = 1;
      end
    end
    if (!done) check("game_bound", 0, 1);
    check("won", int'(ob_won), int'(w));
    check("lost", int'(ob_lost), int'(!w));
    check("error", int'(ob_err), int'(err));
    check("left", int'(ob_gl), cnt);
    check("gv_end", int'(ob_gv), 0);
    rwon = ob_won; rlost = ob_lost; rerr = ob_err; rgl = ob_gl;
    // terminal state holds against stray hints
    for (int i = 0; i < 3; i++) begin
      hv = 1'b1; hint = 2'($urandom_range(0, 3));
      @(negedge clk); hv = 1'b0;
    end
    check("hold_status", int'({ob_won, ob_lost, ob_err, ob_gl, ob_gv}),
          int'({w, !w, err, 3'(cnt), 1'b0}));
    check("hold_guess", int'(ob_guess), g);
    $display("[TB] game dut=%0d secret=%0d guesses=%0h won=%0d lost=%0d error=%0d left=%0d",
             s, secret, seq, rwon, rlost, rerr, rgl);
  endtask

  int q[$];
  int seq, rw, rl, re, rg;

  initial begin
    reset = 1'b1; start = 1'b0; hv = 1'b0; hint = 2'b00; sel = 1'b0;
    #12;
    check("rst_status", int'({ob_gv, ob_won, ob_lost, ob_err}), 0);
    check("rst_guess", int'(ob_guess), 0);
    check("rst_left", int'(ob_gl), 4);
    @(negedge clk); reset = 1'b0;

    // asynchronous reset in the middle of WAIT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_status", int'({ob_gv, ob_won, ob_lost, ob_err}), 0);
    check("arst_guess", int'(ob_guess), 0);
    check("arst_left", int'(ob_gl), 4);
    @(negedge clk); reset = 1'b0;
    $display("[TB] async reset mid-wait done");

    q.delete(); play(0, 7, 0, 0, q, seq, rw, rl, re, rg);
    check("s7_seq", seq, 'h7); check("s7_won", rw, 1); check("s7_left", rg, 3);

    q.delete(); play(0, 14, 0, 0, q, seq, rw, rl, re, rg);
    check("s14_seq", seq, 'h7BDE); check("s14_won", rw, 1); check("s14_left", rg, 0);

    q.delete(); play(0, 10, 0, 0, q, seq, rw, rl, re, rg);
    check("s10_seq", seq, 'h7B9A); check("s10_won", rw, 1); check("s10_left", rg, 0);

    q.delete(); play(0, 4, 0, 20, q, seq, rw, rl, re, rg);
    check("s4_seq", seq, 'h7354); check("s4_won", rw, 1);

    q.delete(); play(0, 15, 0, 0, q, seq, rw, rl, re, rg);
    check("s15_seq", seq, 'h7BDE); check("s15_lost", rl, 1);
    check("s15_err", re, 0); check("s15_left", rg, 0);

    q = '{1, 2, 2, 1}; play(0, 0, 0, 0, q, seq, rw, rl, re, rg);
    check("contra_seq", seq, 'h7B98); check("contra_lost", rl, 1); check("contra_err", re, 1);

    q = '{1, 1, 1, 1, 1}; play(1, 0, 0, 0, q, seq, rw, rl, re, rg);
    check("top_seq", seq, 'h7BDEF); check("top_err", re, 1); check("top_left", rg, 1);

    q = '{2, 2, 2, 2}; play(1, 0, 0, 0, q, seq, rw, rl, re, rg);
    check("bot_seq", seq, 'h7310); check("bot_err", re, 1); check("bot_left", rg, 2);

    for (int n = 0; n < 30; n++) begin
      q.delete();
      play(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), -1, q, seq, rw, rl, re, rg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
